booth_seq_multiplier: RTL
=========================

// Module: booth_seq_multiplier
// PURPOSE
//  Iterative radix-2^RADIX_LOG2 Booth multiplier for the FP mantissa datapath.
//  Recodes multiplier b one overlapping (RADIX_LOG2+1)-bit window per cycle.
//  Adds digit*a, shifted by the window position, into a registered accumulator.
//  Generalises the fixed radix-16, 32-bit combinational partial-product encoder.
//  Adds operand width/radix/signedness parameters, valid/ready handshakes and
//  multi-cycle accumulation.
// PARAMETERS
//  WIDTH       32  operand width in bits; legal range >= 4
//  RADIX_LOG2  4   Booth digit bits per cycle; 1..4 (4 = radix-16, digits -8..+8)
//  SIGNED      1   1: a, b two's complement; 0: a, b unsigned
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          operand pair valid
//  in_ready   out  1          block can accept operands (high only in IDLE)
//  a          in   WIDTH      multiplicand
//  b          in   WIDTH      multiplier (Booth-recoded)
//  out_valid  out  1          product valid, held until taken
//  out_ready  in   1          consumer accepts product
//  product    out  2*WIDTH    a*b, exact, registered
//  busy       out  1          high in RUN or DONE
// BEHAVIOUR
//  Clock and reset
//  - One clock, clk. Reset is asynchronous, active-low: rst_n.
//  - Reset state: state=IDLE, out_valid=0, product=0, busy=0, count=0, acc=0.
//  - in_ready is combinational, = (state==IDLE).
//  Digit recoding
//  - NDIG = ceil((WIDTH + (SIGNED?0:1)) / RADIX_LOG2).
//  - b is extended to NDIG*RADIX_LOG2 bits: sign-extended if SIGNED, else zero-extended.
//  - b[-1] = 0.
//  - Digit i = signed(b[i*R+R-1 : i*R]) + b[i*R-1], where R = RADIX_LOG2.
//  - Digit range is -2^(R-1) .. +2^(R-1).
//  Arithmetic
//  - a is sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to 2*WIDTH+R+1 bits.
//  - The accumulator is 2*WIDTH+R+1 bits.
//  - Each RUN cycle: acc += (digit_i * a_ext) << (i*R), in two's complement.
//  - Overflow beyond bit 2*WIDTH-1 is discarded.
//  - product = acc[2*WIDTH-1:0], which equals the exact a*b.
//  FSM states: IDLE, RUN, DONE
//  - IDLE: in_ready=1. On in_valid && in_ready (the accept edge):
//      capture a and the extended b; acc<=0; count<=0; next state RUN.
//    With in_valid=0, stay in IDLE.
//  - RUN: process digit `count`; count<=count+1.
//      When count==NDIG-1: product<=final acc; out_valid<=1; next state DONE.
//    All inputs except rst_n are ignored in RUN.
//  - DONE: out_valid=1; product held stable.
//      On out_ready: out_valid<=0; next state IDLE.
//    in_ready=0 in DONE: at most one operation in flight, no overlap.
//  Latency and throughput
//  - out_valid rises exactly NDIG edges after the accept edge.
//  - Minimum initiation interval is NDIG+2 cycles.
//  - Digit 0 (zero digit) still takes a cycle: latency is data-independent.
//  Boundary conditions
//  - in_valid asserted in RUN/DONE: ignored; the source must hold it until in_ready.
//  - out_ready held high before completion: no effect until DONE.
//  - rst_n low mid-RUN or in DONE: immediate return to the reset state.
//      The in-flight result is lost; no partial product is emitted.
//  - Most-negative operands (SIGNED=1) need no special case:
//      the extended accumulator absorbs the +2^(R-1) top digit.
// TESTING
//  1. W=32,R=4,S=1: a=7, b=-3 -> product=64'hFFFF_FFFF_FFFF_FFEB; out_valid 8 edges after accept.
//  2. W=32,R=4,S=1: a=b=32'h8000_0000 -> 64'h4000_0000_0000_0000;
//     a=32'h8000_0000, b=32'h7FFF_FFFF -> 64'hC000_0000_8000_0000.
//  3. W=32,R=4,S=0: a=b=32'hFFFF_FFFF -> 64'hFFFF_FFFE_0000_0001; latency 9 edges.
//  4. Backpressure: out_ready=0 for 10 cycles in DONE with in_valid=1 and new operands.
//     -> product stable, in_ready=0, no new accept.
//     -> out_ready=1 returns to IDLE; next operands accepted the following edge.
//  5. rst_n pulsed low on the 3rd RUN cycle -> out_valid=0, product=0, busy=0 at once.
//     -> After release, a=5, b=6 gives product=30.
//  6. Random: 10k operand pairs per config, W in {8,16,32}, R in {1,2,3,4}, S in {0,1}.
//     Random valid/ready stalls; results compared to a*b golden model.

Source files
------------

// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - iterative radix-2^RADIX_LOG2 Booth multiplier, one digit per cycle
module booth_seq_multiplier #(
    parameter int WIDTH      = 32,
    parameter int RADIX_LOG2 = 4,
    parameter int SIGNED     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int R    = RADIX_LOG2;
    localparam int NDIG = (WIDTH + ((SIGNED != 0) ? 0 : 1) + R - 1) / R;
    localparam int BW   = NDIG * R;
    localparam int AW   = 2 * WIDTH + R + 1;
    localparam int CW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [AW-1:0]      r_a;
    logic [BW:0]        r_b;
    logic [AW-1:0]      r_acc;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_product;

    logic               w_accept;
    logic               w_last;
    logic [AW-1:0]      w_a_ext;
    logic [BW-1:0]      w_b_ext;
    logic [R:0]         w_digit;
    logic [R:0]         w_mag;
    logic [AW-1:0]      w_pp;
    logic [AW-1:0]      w_term;
    logic [AW-1:0]      w_sum;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_state == S_RUN) && (r_count == CW'(NDIG - 1));
    assign product  = r_product;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        busy      = (r_state == S_RUN) || (r_state == S_DONE);
        out_valid = (r_state == S_DONE);
    end

    always_comb begin
        w_a_ext = {AW{(SIGNED != 0) && a[WIDTH-1]}};
        w_a_ext[WIDTH-1:0] = a;
        w_b_ext = {BW{(SIGNED != 0) && b[WIDTH-1]}};
        w_b_ext[WIDTH-1:0] = b;
    end

    // r_b[R:0] is always the current overlapping window; r_b[0] is the bit below it.
    always_comb begin
        w_digit = {r_b[R], r_b[R:1]} + {{R{1'b0}}, r_b[0]};
        w_mag   = w_digit[R] ? (~w_digit + (R+1)'(1)) : w_digit;
        w_pp    = '0;
        for (int j = 0; j <= R; j++) begin
            if (w_mag[j]) w_pp = w_pp + (r_a << j);
        end
        w_term  = w_digit[R] ? (~w_pp + AW'(1)) : w_pp;
        w_sum   = r_acc + w_term;
    end

    // r_a is pre-shifted by the window position so each digit adds without a barrel shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a     <= w_a_ext;
            r_b     <= {w_b_ext, 1'b0};
            r_acc   <= '0;
            r_count <= '0;
        end else if (r_state == S_RUN) begin
            r_acc   <= w_sum;
            r_a     <= r_a << R;
            r_b     <= {{R{r_b[BW]}}, r_b[BW:R]};
            r_count <= r_count + CW'(1);
            if (w_last) r_product <= w_sum[2*WIDTH-1:0];
        end
    end
endmodule
